// File: rtl/multi_stride_tracker.sv
// Multi-channel stride completion tracker: per-channel sticky end flags, IDLE/ARMED/DONE
// handshake, completion pulse and saturating stride counter. Optional STRIDE_TIMEOUT_EN.
module stride_lane #(
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  enable,
   input  logic                  ep_valid,
   input  logic                  rd_fire,
   input  logic [ADDR_WIDTH-1:0] read_addr,
   input  logic [ADDR_WIDTH-1:0] end_ptr,
   output logic                  hit
);
   assign hit = enable & ep_valid & rd_fire & (read_addr == end_ptr);
endmodule

module multi_stride_tracker #(
   parameter int ADDR_WIDTH     = 8,
   parameter int NUM_CH         = 4,
   parameter int CNT_WIDTH      = 8,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic [NUM_CH-1:0]            ch_enable,
   input  logic [NUM_CH-1:0]            ep_valid,
   input  logic [NUM_CH-1:0]            rd_fire,
   input  logic [NUM_CH*ADDR_WIDTH-1:0] read_addr,
   input  logic [NUM_CH*ADDR_WIDTH-1:0] end_ptr,
   input  logic                         ack,
   output logic [NUM_CH-1:0]            stride_ended,
   output logic                         busy,
   output logic                         all_ended,
   output logic                         stride_done,
   output logic [CNT_WIDTH-1:0]         stride_count,
   output logic                         timeout
);
   typedef enum logic [1:0] {IDLE, ARMED, DONE} state_t;

   state_t            state;
   logic [NUM_CH-1:0] mask, hit, next_flags;
   logic              all_hit, expire;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
      stride_lane #(.ADDR_WIDTH(ADDR_WIDTH)) u_lane (
         .enable   (mask[g]),
         .ep_valid (ep_valid[g]),
         .rd_fire  (rd_fire[g]),
         .read_addr(read_addr[g*ADDR_WIDTH +: ADDR_WIDTH]),
         .end_ptr  (end_ptr[g*ADDR_WIDTH +: ADDR_WIDTH]),
         .hit      (hit[g])
      );
   end

   assign next_flags = stride_ended | hit;
   assign all_hit    = &next_flags;
   assign busy       = (state == ARMED);
   assign all_ended  = (state == DONE);

`ifdef STRIDE_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] tmo_cnt;

   // Held at zero outside ARMED so every arm starts counting from zero.
   always_ff @(posedge clk) begin
      if (rst || state != ARMED || start) tmo_cnt <= '0;
      else                                tmo_cnt <= tmo_cnt + 1'b1;
   end
   assign expire = (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
   localparam int unused_tmo = TIMEOUT_CYCLES;
   assign expire = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         mask         <= '0;
         stride_ended <= '0;
         stride_done  <= 1'b0;
         stride_count <= '0;
         timeout      <= 1'b0;
      end else begin
         stride_done <= 1'b0;
         // start wins in every state, including over a same-cycle completing hit
         if (start) begin
            state        <= ARMED;
            mask         <= ch_enable;
            stride_ended <= ~ch_enable;
            timeout      <= 1'b0;
         end else begin
            case (state)
               ARMED: begin
                  stride_ended <= next_flags;
                  if (all_hit) begin
                     state       <= DONE;
                     stride_done <= 1'b1;
                     if (stride_count != {CNT_WIDTH{1'b1}})
                        stride_count <= stride_count + 1'b1;
                  end else if (expire) begin
                     state       <= DONE;
                     stride_done <= 1'b1;
                     timeout     <= 1'b1;
                  end
               end
               DONE: begin
                  if (ack) begin
                     state        <= IDLE;
                     stride_ended <= '0;
                     timeout      <= 1'b0;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_multi_stride_tracker.sv
// Directed bench for multi_stride_tracker: stimulus pushes expected post-edge outputs,
// a negedge monitor pops and compares.
module tb_multi_stride_tracker;
   logic             clk = 1'b0;
   logic             rst, start, ack;
   logic [3:0]       ch_enable, ep_valid, rd_fire;
   logic [3:0][7:0]  ra, ep;
   logic [3:0]       stride_ended;
   logic             busy, all_ended, stride_done, timeout;
   logic [7:0]       stride_count;

   typedef struct {
      string      tag;
      logic [3:0] f;
      logic       b, a, d, t;
      logic [7:0] c;
   } exp_t;

   exp_t q[$];
   int   nvec = 0;
   int   nfail = 0;

   always #5 clk = ~clk;

   multi_stride_tracker #(.ADDR_WIDTH(8), .NUM_CH(4), .CNT_WIDTH(8), .TIMEOUT_CYCLES(5)) dut (
      .clk(clk), .rst(rst), .start(start), .ch_enable(ch_enable), .ep_valid(ep_valid),
      .rd_fire(rd_fire), .read_addr(ra), .end_ptr(ep), .ack(ack),
      .stride_ended(stride_ended), .busy(busy), .all_ended(all_ended),
      .stride_done(stride_done), .stride_count(stride_count), .timeout(timeout)
   );

   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         nvec++;
         if ({stride_ended, busy, all_ended, stride_done, timeout, stride_count} !==
             {e.f, e.b, e.a, e.d, e.t, e.c}) begin
            nfail++;
            $display("FAIL %s: got ended=%b busy=%b all=%b done=%b tmo=%b cnt=%0d, want ended=%b busy=%b all=%b done=%b tmo=%b cnt=%0d",
                     e.tag, stride_ended, busy, all_ended, stride_done, timeout, stride_count,
                     e.f, e.b, e.a, e.d, e.t, e.c);
         end
      end
   end

   task automatic drive(input logic s, input logic [3:0] en, input logic [3:0] rf, input logic a);
      start = s; ch_enable = en; rd_fire = rf; ack = a;
   endtask

   // Push what the outputs must be after the next edge, then take that edge.
   task automatic step(input string tag, input logic [3:0] f, input logic b, input logic a,
                       input logic d, input logic [7:0] c, input logic t = 1'b0);
      exp_t e;
      e.tag = tag; e.f = f; e.b = b; e.a = a; e.d = d; e.c = c; e.t = t;
      q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int cnt;
      ep = {8'd40, 8'd30, 8'd20, 8'd10};
      ra = ep;
      ep_valid = 4'b1111;
      rst = 1'b1;
      drive(0, 4'b0000, 4'b0000, 0);
      step("reset", 4'b0000, 0, 0, 0, 8'd0);
      rst = 1'b0;

      // full stride, hits on separate cycles
      drive(1, 4'b1111, 4'b0000, 0); step("arm_all", 4'b0000, 1, 0, 0, 8'd0);
      drive(0, 4'b0000, 4'b0001, 0); step("hit_ch0", 4'b0001, 1, 0, 0, 8'd0);
      drive(0, 4'b0000, 4'b0100, 0); step("hit_ch2", 4'b0101, 1, 0, 0, 8'd0);
      drive(0, 4'b0000, 4'b0010, 0); step("hit_ch1", 4'b0111, 1, 0, 0, 8'd0);
      drive(0, 4'b0000, 4'b1000, 0); step("hit_ch3", 4'b1111, 0, 1, 1, 8'd1);
      drive(0, 4'b0000, 4'b0000, 0); step("done_hold", 4'b1111, 0, 1, 0, 8'd1);
      drive(0, 4'b0000, 4'b0000, 1); step("ack", 4'b0000, 0, 0, 0, 8'd1);
      drive(0, 4'b0000, 4'b0000, 1); step("ack_idle", 4'b0000, 0, 0, 0, 8'd1);

      // partial enable; idle hits ignored
      drive(0, 4'b0000, 4'b1010, 0); step("idle_hits", 4'b0000, 0, 0, 0, 8'd1);
      drive(1, 4'b0101, 4'b0000, 0); step("arm_0101", 4'b1010, 1, 0, 0, 8'd1);
      drive(0, 4'b0000, 4'b0001, 0); step("hit_ch0b", 4'b1011, 1, 0, 0, 8'd1);
      ep_valid = 4'b1011;
      drive(0, 4'b0000, 4'b0100, 0); step("ep_invalid", 4'b1011, 1, 0, 0, 8'd1);
      ep_valid = 4'b1111;
      drive(0, 4'b0000, 4'b0000, 0); step("no_fire", 4'b1011, 1, 0, 0, 8'd1);
      ra[2] = 8'd29;
      drive(0, 4'b0000, 4'b0100, 0); step("addr_29", 4'b1011, 1, 0, 0, 8'd1);
      ra[2] = 8'd31;
      drive(0, 4'b0000, 4'b0100, 0); step("addr_31", 4'b1011, 1, 0, 0, 8'd1);
      ra[2] = 8'd30;
      drive(0, 4'b0000, 4'b0100, 0); step("hit_ch2b", 4'b1111, 0, 1, 1, 8'd2);

      // start+ack in DONE; restart coinciding with the completing hits
      drive(1, 4'b1111, 4'b0000, 1); step("start_ack", 4'b0000, 1, 0, 0, 8'd2);
      drive(1, 4'b1000, 4'b1111, 0); step("restart_hit", 4'b0111, 1, 0, 0, 8'd2);
      drive(0, 4'b0000, 4'b1000, 0); step("hit_ch3b", 4'b1111, 0, 1, 1, 8'd3);
      drive(0, 4'b0000, 4'b0000, 1); step("ack2", 4'b0000, 0, 0, 0, 8'd3);

      // reset mid-stride
      drive(1, 4'b1111, 4'b0000, 0); step("arm_rst", 4'b0000, 1, 0, 0, 8'd3);
      drive(0, 4'b0000, 4'b0011, 0); step("two_hits", 4'b0011, 1, 0, 0, 8'd3);
      rst = 1'b1;
      drive(1, 4'b1111, 4'b1111, 1); step("rst_mid", 4'b0000, 0, 0, 0, 8'd0);
      rst = 1'b0;
      drive(0, 4'b0000, 4'b0000, 0); step("post_rst", 4'b0000, 0, 0, 0, 8'd0);

      // ack while ARMED ignored, then zero-enable restart
      drive(1, 4'b1111, 4'b0000, 0); step("arm3", 4'b0000, 1, 0, 0, 8'd0);
      drive(0, 4'b0000, 4'b0000, 1); step("ack_armed", 4'b0000, 1, 0, 0, 8'd0);
      drive(1, 4'b0000, 4'b0000, 0); step("zero_en", 4'b1111, 1, 0, 0, 8'd0);
      drive(0, 4'b0000, 4'b0000, 0); step("zero_done", 4'b1111, 0, 1, 1, 8'd1);

      // back-to-back zero-enable strides drive the counter into saturation
      cnt = 1;
      for (int i = 0; i < 256; i++) begin
         drive(1, 4'b0000, 4'b0000, 0); step("sat_arm", 4'b1111, 1, 0, 0, 8'(cnt));
         cnt = (cnt < 255) ? cnt + 1 : 255;
         drive(0, 4'b0000, 4'b0000, 0); step("sat_done", 4'b1111, 0, 1, 1, 8'(cnt));
      end
      drive(0, 4'b0000, 4'b0000, 1); step("ack_sat", 4'b0000, 0, 0, 0, 8'd255);

`ifdef STRIDE_TIMEOUT_EN
      // ch3 never hits: DONE after five armed cycles with partial flags
      drive(1, 4'b1111, 4'b0000, 0); step("tmo_arm", 4'b0000, 1, 0, 0, 8'd255);
      drive(0, 4'b0000, 4'b0001, 0); step("tmo_c1", 4'b0001, 1, 0, 0, 8'd255);
      drive(0, 4'b0000, 4'b0010, 0); step("tmo_c2", 4'b0011, 1, 0, 0, 8'd255);
      drive(0, 4'b0000, 4'b0100, 0); step("tmo_c3", 4'b0111, 1, 0, 0, 8'd255);
      drive(0, 4'b0000, 4'b0000, 0); step("tmo_c4", 4'b0111, 1, 0, 0, 8'd255);
      drive(0, 4'b0000, 4'b0000, 0); step("tmo_c5", 4'b0111, 0, 1, 1, 8'd255, 1'b1);
      drive(0, 4'b0000, 4'b0000, 0); step("tmo_hold", 4'b0111, 0, 1, 0, 8'd255, 1'b1);
      drive(0, 4'b0000, 4'b0000, 1); step("tmo_ack", 4'b0000, 0, 0, 0, 8'd255);
`endif

      drive(0, 4'b0000, 4'b0000, 0);
      for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge clk);
      #1;
      if (q.size() != 0) begin
         nfail++;
         $display("FAIL drain: %0d expectations left, want 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end
endmodule

// File: doc/multi_stride_tracker.md
Name: multi_stride_tracker

Overview:
Multi-channel stride completion tracker for the scratchpad read side of the PE array. It generalises the single sticky stride-ended flag to NUM_CH independent read channels, each with its own end pointer. It adds per-channel enable masking, an armed/done state machine with start/ack handshake, a one-cycle completion pulse and a saturating completed-stride counter. The control FSM uses it to learn when every active channel has consumed its stride.

Parameters:
ADDR_WIDTH, 8, width of each read address / end pointer
NUM_CH, 4, number of tracked read channels (1..16)
CNT_WIDTH, 8, width of completed-stride counter
TIMEOUT_CYCLES, 255, armed-cycle limit (used only with STRIDE_TIMEOUT_EN)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous active-high reset
start  input  1  arm tracker: clear flags, capture ch_enable
ch_enable  input  NUM_CH  channels participating in this stride; sampled on start
ep_valid  input  NUM_CH  end_ptr[i] valid
rd_fire  input  NUM_CH  channel i read at read_addr[i] this cycle
read_addr  input  NUM_CH*ADDR_WIDTH  packed read addresses, ch0 in LSBs
end_ptr  input  NUM_CH*ADDR_WIDTH  packed end pointers, ch0 in LSBs
ack  input  1  consumer acknowledges completion
stride_ended  output  NUM_CH  sticky per-channel ended flags
busy  output  1  high in ARMED
all_ended  output  1  high in DONE
stride_done  output  1  one-cycle pulse on ARMED->DONE
stride_count  output  CNT_WIDTH  completed strides since reset, saturating
timeout  output  1  timeout indicator (see Optional Feature)

Behaviour:
- Reset: state IDLE; stride_ended=0, busy=0, all_ended=0, stride_done=0, stride_count=0, timeout=0, captured enable mask=0.
- States: IDLE, ARMED, DONE. busy = (state==ARMED); all_ended = (state==DONE); both derived from registered state.
- IDLE: inputs other than start ignored. start -> ARMED at next edge; mask<=ch_enable; stride_ended[i]<=~ch_enable[i].
- ARMED, per channel: hit[i] = ep_valid[i] & rd_fire[i] & (read_addr[i]==end_ptr[i]). If hit[i], stride_ended[i]<=1. Flag is sticky; never clears in ARMED except on start.
- Completion check in ARMED uses next flags: if &(stride_ended | hit) then state<=DONE, stride_done<=1 for exactly one cycle, stride_count<=stride_count+1 unless it is all-ones (saturate).
- Compare is exact equality, ADDR_WIDTH bits. No wrap or ordering semantics; an address that passes end_ptr without hit never ends the channel.
- start while ARMED: restart. Flags reload from the new ch_enable; stays ARMED; no count, no pulse. start wins over a same-cycle completing hit.
- DONE: flags held. ack -> IDLE with stride_ended cleared to 0. start (with or without ack) -> ARMED as in IDLE, so back-to-back strides carry no idle cycle.
- ack outside DONE is ignored.
- Zero-enable start (ch_enable=0): ARMED for one cycle, then DONE with pulse and count increment on the following edge.
- rst has priority over all inputs in any state, mid-stride included; counter cleared.

Optional Feature:
STRIDE_TIMEOUT_EN: when defined, a counter clears on entry to ARMED and increments each ARMED cycle. Counter width is clog2(TIMEOUT_CYCLES+1). Reaching TIMEOUT_CYCLES with channels still pending forces DONE: stride_done pulses, timeout<=1, stride_count is not incremented, and stride_ended keeps its partial values. timeout clears on leaving DONE or on rst. A completing hit in the same cycle as expiry counts as normal completion (timeout=0). When not defined: no counter is built and timeout is constant 0.

Test Plan:
- NUM_CH=4, start with ch_enable=4'b1111, end_ptr={40,30,20,10}; hits at ch0=10, ch2=30, ch1=20, ch3=40 on separate cycles -> stride_ended steps 0001,0101,0111,1111; stride_done high exactly one cycle on the last edge; stride_count=1; all_ended=1 until ack; after ack IDLE with flags 0.
- ch_enable=4'b0101 -> stride_ended=4'b1010 immediately after start; hits on ch0 and ch2 only -> DONE; ch1/ch3 hits while IDLE ignored.
- ep_valid=0 or rd_fire=0 with read_addr==end_ptr -> no flag set; read_addr stepping 9->11 past end_ptr=10 -> channel stays pending.
- In DONE, start and ack in the same cycle -> ARMED next cycle, flags reloaded, count unchanged; 256 completions with CNT_WIDTH=8 -> stride_count saturates at 255.
- rst asserted while ARMED with 2 flags set -> next cycle all outputs 0, IDLE; a restart start while ARMED coinciding with the final hit -> no pulse, count unchanged.
- With STRIDE_TIMEOUT_EN, TIMEOUT_CYCLES=5 and ch3 never hits -> DONE after 5 armed cycles, timeout=1, stride_count unchanged, stride_ended=4'b0111.
